// File: rtl/imem_stream_loader.sv
// Loads a framed byte stream (SYNC, count hi/lo, big-endian words) into instruction RAM and
// holds the core in reset until a full image lands. Optional trailing XOR check: IMEM_LOADER_CHECKSUM_EN.
module imem_stream_loader #(
    parameter int         DEPTH_LOG2 = 6,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic                  CLK,
    input  logic                  Reset_L,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic [31:0]           Address,
    output logic [31:0]           Data,
    output logic                  cpu_reset_l,
    output logic                  load_done,
    output logic                  load_error,
    output logic [DEPTH_LOG2:0]   words_loaded
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [2:0] {
        S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA, S_COMMIT, S_CHECK, S_DONE, S_ERROR
    } state_t;

    // Handshake: a byte moves on a falling CLK edge where rx_valid & rx_ready are both high.
    // rx_ready drops only for the single COMMIT cycle and while Reset_L is low.

    state_t                state_q, state_d;
    logic [7:0]            cnt_hi_q;
    logic [15:0]           word_cnt_q;
    logic [31:0]           asm_q;
    logic [1:0]            byte_cnt_q;
    logic [DEPTH_LOG2:0]   words_q;
    logic [31:0]           ram [DEPTH];

    logic                  xfer;
    logic                  is_sync;
    logic                  start_frame;
    logic                  last_word;
    logic [15:0]           count_in;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q;
`endif

    assign rx_ready     = Reset_L && (state_q != S_COMMIT);
    assign xfer         = rx_valid && rx_ready;
    assign is_sync      = (rx_data == SYNC_BYTE);
    assign count_in     = {cnt_hi_q, rx_data};
    assign last_word    = ((16'(words_q) + 16'd1) == word_cnt_q);
    assign start_frame  = xfer && is_sync &&
                          (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);

    assign cpu_reset_l  = (state_q == S_DONE);
    assign load_done    = (state_q == S_DONE);
    assign load_error   = (state_q == S_ERROR);
    assign words_loaded = words_q;

    always_ff @(negedge CLK or negedge Reset_L) begin
        if (!Reset_L) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_frame) state_d = S_CNT_HI;
            end
            S_CNT_HI: begin
                if (xfer) state_d = S_CNT_LO;
            end
            S_CNT_LO: begin
                if (xfer) begin
                    if (count_in == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = S_CHECK;
`else
                        state_d = S_DONE;
`endif
                    end else if (count_in > 16'(DEPTH)) begin
                        // Oversize images are refused before anything is written.
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer && byte_cnt_q == 2'd3) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (xfer) state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(negedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            cnt_hi_q   <= 8'h00;
            word_cnt_q <= 16'h0000;
            asm_q      <= 32'h0;
            byte_cnt_q <= 2'd0;
            words_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            if (start_frame) begin
                words_q    <= '0;
                byte_cnt_q <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum_q     <= 8'h00;
`endif
            end
            if (state_q == S_CNT_HI && xfer) cnt_hi_q <= rx_data;
            if (state_q == S_CNT_LO && xfer) word_cnt_q <= count_in;
            if (state_q == S_DATA && xfer) begin
                asm_q      <= {asm_q[23:0], rx_data};
                byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum_q     <= csum_q ^ rx_data;
`endif
            end
            if (state_q == S_COMMIT) words_q <= words_q + 1'b1;
        end
    end

    // RAM has no reset so a loaded image survives a reset pulse.
    always_ff @(negedge CLK) begin
        if (Reset_L && state_q == S_COMMIT)
            ram[words_q[DEPTH_LOG2-1:0]] <= asm_q;
    end

    logic unused_addr_lsb;
    assign unused_addr_lsb = &{1'b0, Address[1:0]};

    always_comb begin
        Data = 32'h0;
        if (Address[31:DEPTH_LOG2+2] == '0) Data = ram[Address[DEPTH_LOG2+1:2]];
    end

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed bench for imem_stream_loader; DUT state changes on negedge, bench drives/samples after posedge.
module tb_imem_stream_loader;

    logic        CLK = 1'b1;
    logic        Reset_L = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [31:0] Address = 32'h0;
    logic [31:0] Data;
    logic        cpu_reset_l;
    logic        load_done;
    logic        load_error;
    logic [6:0]  words_loaded;

    int checks = 0;
    int errors = 0;
    int stalls = 0;

    always #5 CLK = ~CLK;

    imem_stream_loader dut (
        .CLK          (CLK),
        .Reset_L      (Reset_L),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .Address      (Address),
        .Data         (Data),
        .cpu_reset_l  (cpu_reset_l),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Offers one byte and returns just after the posedge following its acceptance; rx_valid stays high.
    task automatic send_byte(input logic [7:0] b);
        int tries;
        tries = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && tries < 8) begin
            stalls++;
            tries++;
            @(posedge CLK); #1;
        end
        if (tries == 8) check_val("rx_ready_timeout", 32'(rx_ready), 32'd1);
        @(negedge CLK);
        @(posedge CLK); #1;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        Address = addr;
        #1;
        check_val(tag, Data, exp);
    endtask

    logic [7:0] frame_a [14] = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h00, 8'h02,
                                 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
    logic [7:0] frame_b [8]  = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h00, 8'h01, 8'h11, 8'h22};
    logic [7:0] frame_c [8]  = '{8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01};

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check_val("rst_rx_ready", 32'(rx_ready), 32'd0);
        check_val("rst_cpu_reset_l", 32'(cpu_reset_l), 32'd0);
        check_val("rst_load_done", 32'(load_done), 32'd0);
        check_val("rst_load_error", 32'(load_error), 32'd0);
        check_val("rst_words", 32'(words_loaded), 32'd0);
        Reset_L = 1'b1;
        #1;
        check_val("post_rst_rx_ready", 32'(rx_ready), 32'd1);
        idle(1);

        // Two-word frame after garbage, rx_valid held high throughout
        stalls = 0;
        for (int i = 0; i < 14; i++) send_byte(frame_a[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h89);
`else
        check_val("commit_rx_ready", 32'(rx_ready), 32'd0);
        check_val("commit_load_done", 32'(load_done), 32'd0);
        check_val("commit_cpu_reset_l", 32'(cpu_reset_l), 32'd0);
        send_byte(8'h00);
`endif
        check_val("a_stalls", 32'(stalls), 32'd2);
        check_val("a_load_done", 32'(load_done), 32'd1);
        check_val("a_cpu_reset_l", 32'(cpu_reset_l), 32'd1);
        check_val("a_words", 32'(words_loaded), 32'd2);
        check_val("a_load_error", 32'(load_error), 32'd0);
        idle(1);
        fetch("a_ram0", 32'h0, 32'h20080005);
        fetch("a_ram1", 32'h4, 32'hAC080000);
        fetch("a_ram1_lsb", 32'h7, 32'hAC080000);
        fetch("a_out_of_range", 32'h400, 32'h0);
        idle(1);

        // Reload from DONE: garbage ignored, SYNC drops core reset, old word readable during COMMIT
        for (int i = 0; i < 3; i++) send_byte(frame_b[i]);
        check_val("b_garbage_done", 32'(load_done), 32'd1);
        check_val("b_garbage_cpu_rst", 32'(cpu_reset_l), 32'd1);
        send_byte(frame_b[3]);
        check_val("b_sync_cpu_rst", 32'(cpu_reset_l), 32'd0);
        check_val("b_sync_words", 32'(words_loaded), 32'd0);
        for (int i = 4; i < 8; i++) send_byte(frame_b[i]);
        send_byte(8'h33);
        Address = 32'h0;
        send_byte(8'h44);
        check_val("b_commit_old_word", Data, 32'h20080005);
        check_val("b_commit_words", 32'(words_loaded), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h44);
`endif
        idle(1);
        check_val("b_load_done", 32'(load_done), 32'd1);
        check_val("b_words", 32'(words_loaded), 32'd1);
        fetch("b_ram0", 32'h0, 32'h11223344);
        fetch("b_ram1_kept", 32'h4, 32'hAC080000);
        idle(1);

        // Oversize counts are refused without touching RAM
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h41);
        check_val("c65_load_error", 32'(load_error), 32'd1);
        check_val("c65_cpu_reset_l", 32'(cpu_reset_l), 32'd0);
        check_val("c65_load_done", 32'(load_done), 32'd0);
        send_byte(8'h00);
        check_val("c65_stays_error", 32'(load_error), 32'd1);
        idle(1);
        fetch("c65_ram0_kept", 32'h0, 32'h11223344);
        idle(1);
        send_byte(8'hA5);
        check_val("c_sync_clears_error", 32'(load_error), 32'd0);
        send_byte(8'h01); send_byte(8'h00);
        check_val("c256_load_error", 32'(load_error), 32'd1);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        idle(1);
        check_val("c0_load_done", 32'(load_done), 32'd1);
        check_val("c0_cpu_reset_l", 32'(cpu_reset_l), 32'd1);
        check_val("c0_words", 32'(words_loaded), 32'd0);
        check_val("c0_load_error", 32'(load_error), 32'd0);

        // Reset mid-frame after 5 data bytes
        for (int i = 0; i < 8; i++) send_byte(frame_c[i]);
        check_val("d_words_mid", 32'(words_loaded), 32'd1);
        rx_valid = 1'b0;
        Reset_L  = 1'b0;
        #1;
        check_val("d_rst_rx_ready", 32'(rx_ready), 32'd0);
        check_val("d_rst_cpu_reset_l", 32'(cpu_reset_l), 32'd0);
        check_val("d_rst_words", 32'(words_loaded), 32'd0);
        idle(1);
        Reset_L = 1'b1;
        idle(1);
        check_val("d_load_done", 32'(load_done), 32'd0);
        check_val("d_cpu_reset_l", 32'(cpu_reset_l), 32'd0);
        fetch("d_ram0_kept", 32'h0, 32'hDEADBEEF);
        fetch("d_ram1_kept", 32'h4, 32'hAC080000);
        idle(1);
        send_byte(8'h00);
        check_val("d_idle_discard", 32'(load_done), 32'd0);
        idle(1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        for (int i = 3; i < 14; i++) send_byte(frame_a[i]);
        send_byte(8'h88);
        check_val("e_bad_csum_error", 32'(load_error), 32'd1);
        check_val("e_bad_csum_cpu_rst", 32'(cpu_reset_l), 32'd0);
        for (int i = 3; i < 14; i++) send_byte(frame_a[i]);
        send_byte(8'h89);
        check_val("e_good_csum_done", 32'(load_done), 32'd1);
        check_val("e_good_csum_cpu_rst", 32'(cpu_reset_l), 32'd1);
        idle(1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
